// File: rtl/disp_value_ctrl.sv
// Debounced load/up/down buttons driving a CNT_W-bit hex counter plus pre-load snapshot.
// Latency: 2 sync clks + DB_TICKS ticks + 1 action clk from a stable raw edge.
module disp_value_ctrl #(
  parameter int DB_TICKS = 4,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [CNT_W-1:0]   SW,
  input  logic               btn_load,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [2*CNT_W-1:0] value_out,
  output logic               wrap
);

  localparam logic [3:0] DB_LAST = 4'(DB_TICKS - 1);

  logic [2:0]       w_raw;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_db;
  logic [2:0]       r_db_q;
  logic [3:0]       r_dbcnt [3];
  logic [2:0]       w_press;
  logic             w_load;
  logic             w_up;
  logic             w_down;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_snap;
  logic             r_wrap;

  // Bit order everywhere: [2]=load, [1]=up, [0]=down.
  assign w_raw = {btn_load, btn_up, btn_down};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Counter holds ticks already seen at the new level; the DB_TICKS-th one commits it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db <= '0;
      for (int i = 0; i < 3; i++) r_dbcnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_dbcnt[i] <= '0;
        end else if (r_dbcnt[i] == DB_LAST) begin
          r_db[i]    <= r_sync2[i];
          r_dbcnt[i] <= '0;
        end else begin
          r_dbcnt[i] <= r_dbcnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_db_q <= '0;
    else        r_db_q <= r_db;
  end

  assign w_press = r_db & ~r_db_q;
  assign w_load  = w_press[2];
  assign w_up    = w_press[1];
  assign w_down  = w_press[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_snap  <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_load) begin
        r_snap  <= r_count;
        r_count <= SW;
      end else if (w_up && !w_down) begin
        r_count <= r_count + 1'b1;
        r_wrap  <= &r_count;
      end else if (w_down && !w_up) begin
        r_count <= r_count - 1'b1;
        r_wrap  <= ~|r_count;
      end
    end
  end

  assign value_out = {r_count, r_snap};
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_disp_value_ctrl.sv
// Directed bench for disp_value_ctrl: DB_TICKS=4, CNT_W=16, tick every 4th clk.
module tb_disp_value_ctrl;

  logic        clk;
  logic        reset;
  logic        tick;
  logic [15:0] SW;
  logic        btn_load;
  logic        btn_up;
  logic        btn_down;
  logic [31:0] value_out;
  logic        wrap;

  int n_checks = 0;
  int n_errors = 0;
  int wrap_total = 0;
  int w0;
  int nt;
  int tcnt = 0;

  disp_value_ctrl #(.DB_TICKS(4), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .SW        (SW),
    .btn_load  (btn_load),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .value_out (value_out),
    .wrap      (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // tick changes 2 time units after a rising edge, so it is stable at every falling edge.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tick = (tcnt == 3);
      tcnt = (tcnt + 1) % 4;
    end
  end

  always @(negedge clk) if (wrap) wrap_total++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive a button pattern {load,up,down} long enough to debounce, then release and settle.
  task automatic press_btns(input logic [2:0] m);
    {btn_load, btn_up, btn_down} = m;
    repeat (40) @(negedge clk);
    {btn_load, btn_up, btn_down} = 3'b000;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    SW = 16'h0000;
    {btn_load, btn_up, btn_down} = 3'b000;
    repeat (5) @(negedge clk);
    check_val("rst_value", value_out, 32'h0000_0000);
    check_val("rst_wrap", {31'd0, wrap}, 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check_val("idle_value", value_out, 32'h0000_0000);

    // Exact latency of the first load: 2 sync clks, then 4 post-sync ticks, then 1 clk.
    SW = 16'h1234;
    btn_load = 1'b1;
    repeat (2) @(negedge clk);
    nt = 0;
    for (int k = 0; k < 40; k++) begin
      if (tick) nt++;
      @(negedge clk);
      if (nt == 4) break;
    end
    check_val("lat_ticks", nt, 4);
    check_val("lat_pre", value_out, 32'h0000_0000);
    @(negedge clk);
    check_val("lat_post", value_out, 32'h1234_0000);
    repeat (80) @(negedge clk);
    check_val("load_held", value_out, 32'h1234_0000);
    btn_load = 1'b0;
    repeat (40) @(negedge clk);
    check_val("load_release", value_out, 32'h1234_0000);

    SW = 16'hBEEF;
    press_btns(3'b100);
    check_val("load2", value_out, 32'hBEEF_1234);

    SW = 16'hFFFE;
    press_btns(3'b100);
    check_val("load_fffe", value_out, 32'hFFFE_BEEF);

    w0 = wrap_total;
    press_btns(3'b010);
    check_val("up_ffff", value_out, 32'hFFFF_BEEF);
    check_val("up_ffff_wrap", wrap_total - w0, 0);
    w0 = wrap_total;
    press_btns(3'b010);
    check_val("up_wrap0", value_out, 32'h0000_BEEF);
    check_val("up_wrap0_pulse", wrap_total - w0, 1);
    w0 = wrap_total;
    press_btns(3'b001);
    check_val("down_wrap", value_out, 32'hFFFF_BEEF);
    check_val("down_wrap_pulse", wrap_total - w0, 1);

    // Each level lasts exactly 2 ticks, never the 4 needed to be accepted.
    btn_up = 1'b1;
    for (int g = 0; g < 6; g++) begin
      repeat (8) @(negedge clk);
      btn_up = ~btn_up;
    end
    btn_up = 1'b0;
    repeat (40) @(negedge clk);
    check_val("glitch_nochange", value_out, 32'hFFFF_BEEF);
    w0 = wrap_total;
    press_btns(3'b010);
    check_val("glitch_then_up", value_out, 32'h0000_BEEF);
    check_val("glitch_then_up_wrap", wrap_total - w0, 1);

    w0 = wrap_total;
    press_btns(3'b011);
    check_val("updown_cancel", value_out, 32'h0000_BEEF);
    check_val("updown_wrap", wrap_total - w0, 0);

    SW = 16'h00AA;
    w0 = wrap_total;
    press_btns(3'b110);
    check_val("load_beats_up", value_out, 32'h00AA_0000);
    check_val("load_up_wrap", wrap_total - w0, 0);

    btn_down = 1'b1;
    repeat (400) @(negedge clk);
    check_val("down_held", value_out, 32'h00A9_0000);
    btn_down = 1'b0;
    repeat (60) @(negedge clk);
    check_val("down_release", value_out, 32'h00A9_0000);

    // Reset in the middle of a debounce must clear instantly and leave no pending action.
    w0 = wrap_total;
    btn_up = 1'b1;
    repeat (12) @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("midrst_value", value_out, 32'h0000_0000);
    check_val("midrst_wrap", {31'd0, wrap}, 32'd0);
    btn_up = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    check_val("post_rst_value", value_out, 32'h0000_0000);
    check_val("post_rst_wrap", wrap_total - w0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
